// File: rtl/slink_pkg.sv
// ---------------------------------------------------------------------------
// slink_pkg
// Shared definitions for the SLINK receive-side unpacker:
//   - bit positions of the SOP/EOP flags in the 18-bit FIFO word
//   - err_code values reported with pkt_err
//   - parser state encoding
//   - saturating 16-bit increment used by the statistics counters
// ---------------------------------------------------------------------------
package slink_pkg;

    localparam int SOP_BIT = 17;
    localparam int EOP_BIT = 16;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_NOSOP  = 3'd1;
    localparam logic [2:0] ERR_LEN    = 3'd2;
    localparam logic [2:0] ERR_EOP    = 3'd3;
    localparam logic [2:0] ERR_SUM    = 3'd4;
    localparam logic [2:0] ERR_RESYNC = 3'd5;
    localparam logic [2:0] ERR_TOUT   = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/slink_bank_mgr.sv
// ---------------------------------------------------------------------------
// slink_bank_mgr
// Tracks the busy state of the two ping-pong buffer banks.
//   clk_i / rst_ni   clock, async active-low reset (both banks free)
//   set_i            mark set_bank_i busy (good packet stored)
//   rel_i[1:0]       host release pulses, one bit per bank
//   fill_act_i       a frame is currently being parsed into fill_bank_i
//   free_any_o       at least one bank is free
//   free_bank_o      lowest-numbered free bank (valid with free_any_o)
// Selection looks at the registered flags only, so a release arriving in
// the same cycle as a selection becomes visible one cycle later.
// ---------------------------------------------------------------------------
module slink_bank_mgr (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_i,
    input  logic       set_bank_i,
    input  logic [1:0] rel_i,
    input  logic       fill_act_i,
    input  logic       fill_bank_i,
    output logic       free_any_o,
    output logic       free_bank_o
);

    logic [1:0] busy_q, busy_d;
    logic [1:0] rel_eff;

    always_comb begin
        rel_eff = rel_i;
        // the host cannot free the bank we are writing into
        if (fill_act_i) rel_eff[fill_bank_i] = 1'b0;
        busy_d = busy_q & ~rel_eff;
        if (set_i) busy_d[set_bank_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= 2'b00;
        else         busy_q <= busy_d;
    end

    assign free_any_o  = ~&busy_q;
    assign free_bank_o = busy_q[0];

endmodule

// File: rtl/slink_rx_unpack.sv
// ---------------------------------------------------------------------------
// slink_rx_unpack
// Reads framed words from the SLINK RX FIFO, validates header length,
// framing and checksum, writes the payload into one bank of a ping-pong
// buffer and reports good / discarded packets.
//   clk_12_5m, rst_12_5m          clock, async active-low reset
//   slink_mm_empty/dval/data      FIFO read side ([17]=SOP [16]=EOP)
//   mm_slink_rdreq                FIFO read request (combinational)
//   buf_wr_en/addr/data           buffer write port, addr = {bank, offset}
//   bank_rel[1:0]                 host frees a bank (one-cycle pulse)
//   pkt_done/pkt_bank/pkt_len     good packet stored
//   pkt_err/err_code              packet discarded and why
//   pkt_ok_cnt/pkt_err_cnt        saturating counters
// Build option: define SLINK_RX_UNPACK_STAT_EN to implement the counters;
// otherwise they read as zero.
//
// state | meaning
// IDLE  | waiting for a free bank and FIFO data; issues the header read
// HDR   | header read in flight; checks SOP and length
// BODY  | reading payload + checksum, writing payload to the bank
// DRAIN | frame broken; reading and dropping its remaining words
// ---------------------------------------------------------------------------
module slink_rx_unpack
    import slink_pkg::*;
#(
    parameter int BUF_AW   = 9,
    parameter int MAX_LEN  = 250,
    parameter int TOUT_CYC = 1024
) (
    input  logic              clk_12_5m,
    input  logic              rst_12_5m,
    input  logic              slink_mm_empty,
    input  logic              slink_mm_dval,
    input  logic [17:0]       slink_mm_data,
    output logic              mm_slink_rdreq,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [15:0]       buf_wr_data,
    input  logic [1:0]        bank_rel,
    output logic              pkt_done,
    output logic              pkt_bank,
    output logic [15:0]       pkt_len,
    output logic              pkt_err,
    output logic [2:0]        err_code,
    output logic [15:0]       pkt_ok_cnt,
    output logic [15:0]       pkt_err_cnt
);

    localparam int          OW        = BUF_AW - 1;
    localparam int          TW        = $clog2(TOUT_CYC) + 1;
    localparam logic [TW-1:0] TOUT_LOAD = TW'(TOUT_CYC - 1);
    localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);

    state_e              state_q, state_d;
    logic                bank_q, bank_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         sum_q, sum_d;
    logic [15:0]         req_q, req_d;
    logic [15:0]         rcv_q, rcv_d;
    logic [TW-1:0]       tout_q, tout_d;
    logic                rd_pend_q;
    logic                wr_en_q, wr_en_d;
    logic [BUF_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                pbank_q, pbank_d;
    logic [15:0]         plen_q, plen_d;
    logic                err_q, err_d;
    logic [2:0]          code_q, code_d;
    logic                rdreq;
    logic                free_any, free_bank;

    logic        w_sop, w_eop;
    logic [15:0] w_data;

    assign w_sop  = slink_mm_data[SOP_BIT];
    assign w_eop  = slink_mm_data[EOP_BIT];
    assign w_data = slink_mm_data[15:0];

    slink_bank_mgr u_bank_mgr (
        .clk_i       (clk_12_5m),
        .rst_ni      (rst_12_5m),
        .set_i       (done_d),
        .set_bank_i  (bank_q),
        .rel_i       (bank_rel),
        .fill_act_i  (state_q != IDLE),
        .fill_bank_i (bank_q),
        .free_any_o  (free_any),
        .free_bank_o (free_bank)
    );

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        len_d     = len_q;
        sum_d     = sum_q;
        req_d     = req_q;
        rcv_d     = rcv_q;
        tout_d    = TOUT_LOAD;
        rdreq     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        pbank_d   = pbank_q;
        plen_d    = plen_q;
        err_d     = 1'b0;
        code_d    = ERR_NONE;

        unique case (state_q)
            IDLE: begin
                if (free_any && !slink_mm_empty) begin
                    rdreq   = 1'b1;
                    bank_d  = free_bank;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (slink_mm_dval) begin
                    if (!w_sop) begin
                        err_d   = 1'b1;
                        code_d  = ERR_NOSOP;
                        state_d = IDLE;
                    end else if (w_data == 16'd0 || w_data > LEN_MAX) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = IDLE;
                    end else begin
                        len_d   = w_data;
                        sum_d   = w_data;
                        req_d   = w_data + 16'd1;   // payload + checksum
                        rcv_d   = 16'd0;
                        state_d = BODY;
                    end
                end
            end
            BODY, DRAIN: begin
                rdreq = !slink_mm_empty && (req_q != 16'd0);
                if (rdreq) req_d = req_q - 16'd1;

                // starvation timer; a stalled drain just gives up quietly
                if (slink_mm_empty && req_q != 16'd0) begin
                    if (tout_q == '0) begin
                        state_d = IDLE;
                        req_d   = 16'd0;
                        if (state_q == BODY) begin
                            err_d  = 1'b1;
                            code_d = ERR_TOUT;
                        end
                    end else begin
                        tout_d = tout_q - TW'(1);
                    end
                end

                if (state_q == DRAIN) begin
                    if (req_q == 16'd0 && !rd_pend_q) state_d = IDLE;
                end else if (slink_mm_dval) begin
                    if (rcv_q == len_q) begin
                        state_d = IDLE;
                        if (!w_eop) begin
                            err_d  = 1'b1;
                            code_d = ERR_EOP;
                        end else if (w_data != sum_q) begin
                            err_d  = 1'b1;
                            code_d = ERR_SUM;
                        end else begin
                            done_d  = 1'b1;
                            pbank_d = bank_q;
                            plen_d  = len_q;
                        end
                    end else if (w_sop) begin
                        err_d   = 1'b1;
                        code_d  = ERR_RESYNC;
                        state_d = DRAIN;
                    end else if (w_eop) begin
                        err_d   = 1'b1;
                        code_d  = ERR_EOP;
                        state_d = DRAIN;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {bank_q, rcv_q[OW-1:0]};
                        wr_data_d = w_data;
                        sum_d     = sum_q + w_data;
                        rcv_d     = rcv_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            state_q   <= IDLE;
            bank_q    <= 1'b0;
            len_q     <= 16'd0;
            sum_q     <= 16'd0;
            req_q     <= 16'd0;
            rcv_q     <= 16'd0;
            tout_q    <= TOUT_LOAD;
            rd_pend_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 16'd0;
            done_q    <= 1'b0;
            pbank_q   <= 1'b0;
            plen_q    <= 16'd0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            req_q     <= req_d;
            rcv_q     <= rcv_d;
            tout_q    <= tout_d;
            rd_pend_q <= rdreq;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            pbank_q   <= pbank_d;
            plen_q    <= plen_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign mm_slink_rdreq = rdreq;
    assign buf_wr_en      = wr_en_q;
    assign buf_wr_addr    = wr_addr_q;
    assign buf_wr_data    = wr_data_q;
    assign pkt_done       = done_q;
    assign pkt_bank       = pbank_q;
    assign pkt_len        = plen_q;
    assign pkt_err        = err_q;
    assign err_code       = code_q;

`ifdef SLINK_RX_UNPACK_STAT_EN
    logic [15:0] ok_cnt_q, err_cnt_q;

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (done_d) ok_cnt_q  <= sat_inc16(ok_cnt_q);
            if (err_d)  err_cnt_q <= sat_inc16(err_cnt_q);
        end
    end

    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;
`else
    assign pkt_ok_cnt  = 16'd0;
    assign pkt_err_cnt = 16'd0;
`endif

endmodule
